// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file and its scoreboard.
// Index 0 and out-of-range indices are treated as the zero register.
package regfile_pkg;

  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_NUM_REGS = 32;

  function automatic logic idx_valid(
    input int unsigned idx,
    input int unsigned num = DEFAULT_NUM_REGS
  );
    return (idx != 0) && (idx < num);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-flag scoreboard: claims set flags, writebacks clear them.
// Claim beats clear on the same index; count follows the flag population.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int IDX_W    = $clog2(NUM_REGS),
  parameter int CNT_W    = $clog2(NUM_REGS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             claim_en,
  input  logic [IDX_W-1:0] claim_idx,
  input  logic             clear_en,
  input  logic [IDX_W-1:0] clear_idx,
  input  logic [IDX_W-1:0] look_a,
  input  logic [IDX_W-1:0] look_b,
  output logic             busy_a,
  output logic             busy_b,
  output logic [CNT_W-1:0] busy_count
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                claim_ok;
  logic                clear_ok;
  logic                inc;
  logic                dec;

  // Next-state flags and population delta
  always_comb begin
    claim_ok = claim_en && idx_valid(32'(claim_idx), NUM_REGS);
    clear_ok = clear_en && idx_valid(32'(clear_idx), NUM_REGS);
    busy_nxt = busy;
    if (clear_ok) busy_nxt[clear_idx] = 1'b0;
    if (claim_ok) busy_nxt[claim_idx] = 1'b1;
    inc = claim_ok && !busy[claim_idx];
    dec = clear_ok && busy[clear_idx]
          && !(claim_ok && (claim_idx == clear_idx));
    cnt_nxt = busy_count + CNT_W'(inc) - CNT_W'(dec);
  end

  // Lookups see the flags as they will be after this edge
  always_comb begin
    busy_a = idx_valid(32'(look_a), NUM_REGS) && busy_nxt[look_a];
    busy_b = idx_valid(32'(look_b), NUM_REGS) && busy_nxt[look_b];
  end

  // Flag vector and count registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_count <= cnt_nxt;
    end
  end

endmodule

// File: rtl/reg_file_scoreboard.sv
// Two-read, one-write register file with write bypass and busy scoreboard.
// Register 0 reads as zero; reads are registered with one-edge latency.
module reg_file_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          readEnable,
  input  logic [IDX_W-1:0]              rdIndexA,
  input  logic [IDX_W-1:0]              rdIndexB,
  output logic [DATA_W-1:0]             rdDataA,
  output logic [DATA_W-1:0]             rdDataB,
  output logic                          rdBusyA,
  output logic                          rdBusyB,
  input  logic                          writeEnable,
  input  logic [IDX_W-1:0]              wrIndex,
  input  logic [DATA_W-1:0]             wrData,
  input  logic                          claimEnable,
  input  logic [IDX_W-1:0]              claimIndex,
  output logic [$clog2(NUM_REGS+1)-1:0] busyCount
);

  localparam int CNT_W = $clog2(NUM_REGS + 1);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_ok;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic              nb_a;
  logic              nb_b;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W),
    .CNT_W    (CNT_W)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .claim_en   (claimEnable),
    .claim_idx  (claimIndex),
    .clear_en   (writeEnable),
    .clear_idx  (wrIndex),
    .look_a     (rdIndexA),
    .look_b     (rdIndexB),
    .busy_a     (nb_a),
    .busy_b     (nb_b),
    .busy_count (busyCount)
  );

  // Read data selection with same-cycle write bypass
  always_comb begin
    wr_ok  = writeEnable && idx_valid(32'(wrIndex), NUM_REGS);
    data_a = '0;
    data_b = '0;
    if (idx_valid(32'(rdIndexA), NUM_REGS))
      data_a = (wr_ok && wrIndex == rdIndexA) ? wrData : regs[rdIndexA];
    if (idx_valid(32'(rdIndexB), NUM_REGS))
      data_b = (wr_ok && wrIndex == rdIndexB) ? wrData : regs[rdIndexB];
  end

  // Register array; entry 0 is never written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wrIndex] <= wrData;
    end
  end

  // Registered read ports, held while readEnable is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdDataA <= '0;
      rdDataB <= '0;
      rdBusyA <= 1'b0;
      rdBusyB <= 1'b0;
    end else if (readEnable) begin
      rdDataA <= data_a;
      rdDataB <= data_b;
      rdBusyA <= nb_a;
      rdBusyB <= nb_b;
    end
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Randomized and directed bench for reg_file_scoreboard.
// Reference model: plain arrays of values and busy bits, count by popcount.
module tb_reg_file_scoreboard;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        readEnable = 1'b0;
  logic [4:0]  rdIndexA = '0;
  logic [4:0]  rdIndexB = '0;
  logic [31:0] rdDataA;
  logic [31:0] rdDataB;
  logic        rdBusyA;
  logic        rdBusyB;
  logic        writeEnable = 1'b0;
  logic [4:0]  wrIndex = '0;
  logic [31:0] wrData = '0;
  logic        claimEnable = 1'b0;
  logic [4:0]  claimIndex = '0;
  logic [5:0]  busyCount;

  int total = 0;
  int bad = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];
  logic [31:0] e_da, e_db;
  bit          e_ba, e_bb;

  reg_file_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .readEnable  (readEnable),
    .rdIndexA    (rdIndexA),
    .rdIndexB    (rdIndexB),
    .rdDataA     (rdDataA),
    .rdDataB     (rdDataB),
    .rdBusyA     (rdBusyA),
    .rdBusyB     (rdBusyB),
    .writeEnable (writeEnable),
    .wrIndex     (wrIndex),
    .wrData      (wrData),
    .claimEnable (claimEnable),
    .claimIndex  (claimIndex),
    .busyCount   (busyCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pop();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    e_da = '0; e_db = '0; e_ba = 1'b0; e_bb = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".da"}, 64'(rdDataA), 64'(e_da));
    chk({tag, ".db"}, 64'(rdDataB), 64'(e_db));
    chk({tag, ".ba"}, 64'(rdBusyA), 64'(e_ba));
    chk({tag, ".bb"}, 64'(rdBusyB), 64'(e_bb));
    chk({tag, ".cnt"}, 64'(busyCount), 64'(pop()));
  endtask

  task automatic cyc(input string tag, input bit re, input logic [4:0] a,
                     input logic [4:0] b, input bit we,
                     input logic [4:0] wi, input logic [31:0] wd,
                     input bit ce, input logic [4:0] ci);
    @(negedge clk);
    readEnable = re; rdIndexA = a; rdIndexB = b;
    writeEnable = we; wrIndex = wi; wrData = wd;
    claimEnable = ce; claimIndex = ci;
    if (we && wi != 0) begin
      m_regs[wi] = wd;
      m_busy[wi] = 1'b0;
    end
    if (ce && ci != 0) m_busy[ci] = 1'b1;
    if (re) begin
      e_da = m_regs[a]; e_db = m_regs[b];
      e_ba = m_busy[a]; e_bb = m_busy[b];
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_clear();
    #12;
    check_all("rst_init");
    @(negedge clk);
    reset = 1'b0;

    cyc("t1_pre", 0, 0, 0, 1, 5, 32'h0BAD_F00D, 1, 3);
    cyc("t1_rd", 1, 5, 3, 0, 0, 0, 0, 0);
    chk("t1_nonzero", 64'(rdDataA), 64'h0BAD_F00D);
    @(negedge clk);
    writeEnable = 1; wrIndex = 5; wrData = 32'hDEAD_BEEF;
    claimEnable = 1; claimIndex = 7; readEnable = 1;
    #2 reset = 1'b1;
    #1;
    model_clear();
    check_all("t1_async");
    @(negedge clk);
    writeEnable = 0; claimEnable = 0; readEnable = 0;
    #1 check_all("t1_hold_rst");
    @(negedge clk);
    reset = 1'b0;
    cyc("t1_after", 1, 5, 7, 0, 0, 0, 0, 0);
    chk("t1_r5", 64'(rdDataA), 64'h0);
    chk("t1_cnt", 64'(busyCount), 64'h0);

    cyc("t2_wr", 0, 0, 0, 1, 3, 32'h1234_5678, 0, 0);
    cyc("t2_rd", 1, 3, 0, 0, 0, 0, 0, 0);
    chk("t2_a", 64'(rdDataA), 64'h1234_5678);
    chk("t2_b", 64'(rdDataB), 64'h0);

    cyc("t3_byp", 1, 9, 9, 1, 9, 32'hA5A5_A5A5, 0, 0);
    chk("t3_a", 64'(rdDataA), 64'hA5A5_A5A5);
    chk("t3_b", 64'(rdDataB), 64'hA5A5_A5A5);

    cyc("t4_c4", 0, 0, 0, 0, 0, 0, 1, 4);
    chk("t4_cnt1", 64'(busyCount), 64'd1);
    cyc("t4_c6", 1, 4, 6, 0, 0, 0, 1, 6);
    chk("t4_cnt2", 64'(busyCount), 64'd2);
    chk("t4_b6", 64'(rdBusyB), 64'd1);
    cyc("t4_w4", 0, 0, 0, 1, 4, 32'h44, 0, 0);
    chk("t4_cnt3", 64'(busyCount), 64'd1);
    cyc("t4_cw6", 1, 6, 6, 1, 6, 32'h66, 1, 6);
    chk("t4_cnt4", 64'(busyCount), 64'd1);
    chk("t4_busy6", 64'(rdBusyA), 64'd1);
    chk("t4_d6", 64'(rdDataA), 64'h66);

    cyc("t5_r0", 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 1, 0);
    chk("t5_cnt", 64'(busyCount), 64'd1);
    cyc("t5_rd", 1, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_d", 64'(rdDataA), 64'h0);
    chk("t5_bz", 64'(rdBusyA), 64'h0);

    cyc("t6_rd", 1, 3, 3, 0, 0, 0, 0, 0);
    cyc("t6_wr", 0, 3, 3, 1, 3, 32'h1, 0, 0);
    chk("t6_hold", 64'(rdDataA), 64'h1234_5678);
    idle();
    chk("t6_hold2", 64'(rdDataA), 64'h1234_5678);
    cyc("t6_re", 1, 3, 0, 0, 0, 0, 0, 0);
    chk("t6_new", 64'(rdDataA), 64'h1);

    for (int n = 0; n < 400; n++) begin
      logic [4:0] a, b, wi, ci;
      a  = 5'($urandom_range(0, 7));
      b  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      wi = 5'($urandom_range(0, 7));
      ci = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) wi = a;
      if ($urandom_range(0, 5) == 0) ci = wi;
      cyc("rnd", 1'($urandom), a, b, 1'($urandom), wi, $urandom,
          ($urandom_range(0, 2) == 0), ci);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
